feistel_round_ctrl: RTL and testbench

- Iterative block-cipher engine that runs one 64-bit block through ROUNDS Feistel rounds, one round per clock.
- Each round uses the existing combinational `fcell` (encrypt) or `ifcell` (decrypt), which take a 64-bit state and a 32-bit round key.
- Handles the 256-bit key schedule, round sequencing and valid/ready handshakes on both sides.
- Sits between the host block stream and the cipher cells; it is the single owner of the round datapath.

---
 rtl/feistel_pkg.sv | 16 +
 rtl/feistel_cells.sv | 20 ++
 rtl/feistel_key_sel.sv | 25 ++
 rtl/feistel_round_ctrl.sv | 78 +++++++
 tb/tb_feistel_round_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/feistel_pkg.sv
// Shared types, widths and the round function for the Feistel round engine.
package feistel_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam int BLOCK_W = 64;
   localparam int KEY_W   = 256;
   localparam int RK_W    = 32;
   localparam int NKEYS   = 8;

   // Mixing function applied to one half; need not be invertible.
   function automatic logic [RK_W-1:0] round_f(input logic [RK_W-1:0] x, input logic [RK_W-1:0] k);
      logic [RK_W-1:0] t;
      t = x + k;
      return {t[RK_W-6:0], t[RK_W-1:RK_W-5]} ^ x ^ 32'h9E37_79B9;
   endfunction
endpackage

// File: rtl/feistel_cells.sv
// Combinational Feistel round cells: fcell encrypts one round, ifcell undoes it.
module fcell
   import feistel_pkg::*;
(
   input  logic [BLOCK_W-1:0] din,
   input  logic [RK_W-1:0]    rk,
   output logic [BLOCK_W-1:0] dout
);
   assign dout = {din[RK_W-1:0], din[BLOCK_W-1:RK_W] ^ round_f(din[RK_W-1:0], rk)};
endmodule

module ifcell
   import feistel_pkg::*;
(
   input  logic [BLOCK_W-1:0] din,
   input  logic [RK_W-1:0]    rk,
   output logic [BLOCK_W-1:0] dout
);
   assign dout = {din[RK_W-1:0] ^ round_f(din[BLOCK_W-1:RK_W], rk), din[BLOCK_W-1:RK_W]};
endmodule

// File: rtl/feistel_key_sel.sv
// Round-key selection: forward order K0..K7 repeated, last eight rounds reversed.
module feistel_key_sel
   import feistel_pkg::*;
#(
   parameter int ROUNDS = 32,
   parameter int CW     = $clog2(ROUNDS)
)(
   input  logic [KEY_W-1:0] key,
   input  logic [CW-1:0]    rnd,
   input  logic             mode,
   output logic [RK_W-1:0]  rk
);
   localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

   logic [CW-1:0] er;
   logic [2:0]    widx;

   // Decrypt walks the encrypt schedule backwards.
   always_comb begin
      er = mode ? (LAST - rnd) : rnd;
      if (32'(er) < 32'(ROUNDS - NKEYS)) widx = er[2:0];
      else                               widx = 3'd7 - er[2:0];
      rk = key[{widx, 5'd0} +: RK_W];
   end
endmodule

// File: rtl/feistel_round_ctrl.sv
// Iterative Feistel engine: one round per clock, valid/ready on both sides.
module feistel_round_ctrl
   import feistel_pkg::*;
#(
   parameter  int ROUNDS = 32,
   localparam int CW     = $clog2(ROUNDS)
)(
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               IN_VALID,
   output logic               IN_READY,
   input  logic               MODE,
   input  logic [BLOCK_W-1:0] IN,
   input  logic [KEY_W-1:0]   KEY,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic [BLOCK_W-1:0] OUT,
   output logic               BUSY
);
   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [BLOCK_W-1:0] blk_q, enc, dec, nxt;
   logic [KEY_W-1:0]   key_q;
   logic               mode_q, live_q, accept, last;
   logic [RK_W-1:0]    rk;

   feistel_key_sel #(.ROUNDS(ROUNDS), .CW(CW)) u_key_sel (
      .key(key_q), .rnd(cnt_q), .mode(mode_q), .rk(rk)
   );
   fcell  u_fcell  (.din(blk_q), .rk(rk), .dout(enc));
   ifcell u_ifcell (.din(blk_q), .rk(rk), .dout(dec));

   assign nxt    = mode_q ? dec : enc;
   assign last   = (cnt_q == CW'(ROUNDS - 1));
   assign accept = IN_VALID && IN_READY;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    if (OUT_READY) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // live_q keeps IN_READY low while reset is held without mixing RST_N into data paths.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         live_q <= 1'b0;
         cnt_q  <= '0;
         blk_q  <= '0;
         key_q  <= '0;
         mode_q <= 1'b0;
      end else begin
         live_q <= 1'b1;
         if (accept) begin
            blk_q  <= IN;
            key_q  <= KEY;
            mode_q <= MODE;
            cnt_q  <= '0;
         end else if (state_q == RUN) begin
            blk_q <= nxt;
            if (!last) cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign IN_READY  = live_q && (state_q == IDLE);
   assign OUT_VALID = (state_q == DONE);
   assign OUT       = blk_q;
   assign BUSY      = (state_q == RUN) || (state_q == DONE);
endmodule

// File: tb/tb_feistel_round_ctrl.sv
// Scoreboard bench for feistel_round_ctrl: 32-round and 8-round builds against a plain reference model.
module tb_feistel_round_ctrl;
   typedef struct {
      logic [63:0] exp;
      int          acc;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid [2];
   logic        in_ready [2];
   logic        mode     [2];
   logic        out_valid[2];
   logic        out_ready[2];
   logic        busy     [2];
   logic [63:0] blk      [2];
   logic [63:0] res      [2];
   logic [255:0] key     [2];

   int checks = 0;
   int errors = 0;
   int cyc[2];
   int last_acc[2];
   int last_hs[2];
   logic [63:0] last_out[2];
   ent_t sb0[$];
   ent_t sb1[$];

   always #5 clk = ~clk;

   feistel_round_ctrl #(.ROUNDS(32)) dut32 (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
      .MODE(mode[0]), .IN(blk[0]), .KEY(key[0]), .OUT_VALID(out_valid[0]),
      .OUT_READY(out_ready[0]), .OUT(res[0]), .BUSY(busy[0])
   );

   feistel_round_ctrl #(.ROUNDS(8)) dut8 (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
      .MODE(mode[1]), .IN(blk[1]), .KEY(key[1]), .OUT_VALID(out_valid[1]),
      .OUT_READY(out_ready[1]), .OUT(res[1]), .BUSY(busy[1])
   );

   function automatic logic [31:0] mix(input logic [31:0] x, input logic [31:0] k);
      logic [31:0] t;
      t = x + k;
      return ((t << 5) | (t >> 27)) ^ x ^ 32'h9E3779B9;
   endfunction

   // Whole-block reference: build the schedule, then run rounds forward or undo them backward.
   function automatic logic [63:0] model(input logic [63:0] b, input logic [255:0] k,
                                         input logic dec, input int rounds);
      logic [31:0] ks [32];
      logic [31:0] l, r, t;
      for (int i = 0; i < rounds; i++) begin
         int w;
         w = (i < rounds - 8) ? (i % 8) : (7 - (i % 8));
         ks[i] = k[32*w +: 32];
      end
      l = b[63:32];
      r = b[31:0];
      if (!dec) begin
         for (int i = 0; i < rounds; i++) begin
            t = r; r = l ^ mix(r, ks[i]); l = t;
         end
      end else begin
         for (int i = rounds - 1; i >= 0; i--) begin
            t = l; l = r ^ mix(l, ks[i]); r = t;
         end
      end
      return {l, r};
   endfunction

   task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   function automatic int sb_size(input int d);
      return (d == 0) ? sb0.size() : sb1.size();
   endfunction

   task automatic mon(input int d, input int rounds);
      ent_t e;
      bit seen;
      bit hs, acc;
      logic [63:0] held;
      seen = 0;
      held = '0;
      forever begin
         @(posedge clk);
         hs  = out_valid[d] && out_ready[d];
         acc = in_valid[d] && in_ready[d];
         cyc[d]++;
         if (acc) begin
            e.exp = model(blk[d], key[d], mode[d], rounds);
            e.acc = cyc[d];
            last_acc[d] = cyc[d];
            if (d == 0) sb0.push_back(e); else sb1.push_back(e);
         end
         #1;
         if (!rst_n) begin
            if (d == 0) sb0.delete(); else sb1.delete();
            seen = 0;
            continue;
         end
         if (hs) begin
            last_hs[d] = cyc[d];
            seen = 0;
         end
         if (out_valid[d]) begin
            if (!seen) begin
               seen = 1;
               held = res[d];
               last_out[d] = res[d];
               if (sb_size(d) == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out_valid dut=%0d got=%h exp=none", d, res[d]);
               end else begin
                  e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                  chk("out_value", res[d], e.exp);
                  chk("latency", 64'(cyc[d] - e.acc), 64'(rounds));
               end
            end else begin
               chk("out_hold", res[d], held);
            end
         end
      end
   endtask

   initial mon(0, 32);
   initial mon(1, 8);

   task automatic send(input int d, input logic [63:0] b, input logic [255:0] k, input logic m);
      bit ok;
      ok = 0;
      @(negedge clk);
      in_valid[d] = 1'b1; blk[d] = b; key[d] = k; mode[d] = m;
      for (int i = 0; i < 200; i++) begin
         if (in_ready[d]) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout dut=%0d got=no_accept exp=accept", d);
      end
      @(negedge clk);
      // Scramble inputs after accept; the block in flight must not notice.
      in_valid[d] = 1'b0;
      blk[d] = {$urandom, $urandom};
      key[d] = {8{$urandom}};
      mode[d] = ~m;
   endtask

   task automatic wait_idle(input int d);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy[d] && sb_size(d) == 0) return;
      end
      checks++; errors++;
      $display("FAIL done_timeout dut=%0d got=busy exp=idle", d);
   endtask

   logic [63:0]  a, ct, b2;
   logic [255:0] k;
   bit           seen_v;

   initial begin
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 0; mode[d] = 0; out_ready[d] = 1; blk[d] = '0; key[d] = '0;
         cyc[d] = 0; last_acc[d] = 0; last_hs[d] = 0; last_out[d] = '0;
      end
      #1;
      chk("rst_in_ready", 64'(in_ready[0]), 64'd0);
      chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
      chk("rst_busy", 64'(busy[0]), 64'd0);
      chk("rst_out", res[0], 64'd0);
      #21 rst_n = 1'b1;

      // Round trip with ascending key words.
      a = 64'hDEADBEEFBAADF00D;
      k = {32'hFEDCBA98, 32'hCDEF0123, 32'hABCDEF01, 32'h89ABCDEF,
           32'h6789ABCD, 32'h456789AB, 32'h23456789, 32'h01234567};
      send(0, a, k, 1'b0); wait_idle(0);
      ct = model(a, k, 1'b0, 32);
      send(0, ct, k, 1'b1); wait_idle(0);
      chk("round_trip", last_out[0], 64'hDEADBEEFBAADF00D);

      // Uniform key, then random blocks/keys/modes.
      send(0, a, {8{32'h01234567}}, 1'b0); wait_idle(0);
      for (int i = 0; i < 10; i++) begin
         send(0, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom}, 1'($urandom % 2));
         wait_idle(0);
      end

      // Backpressure in DONE.
      out_ready[0] = 1'b0;
      send(0, {$urandom, $urandom}, {8{$urandom}}, 1'b0);
      for (int i = 0; i < 100 && !out_valid[0]; i++) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         chk("bp_out_valid", 64'(out_valid[0]), 64'd1);
         chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
         @(negedge clk);
      end
      out_ready[0] = 1'b1;
      @(posedge clk); #2;
      chk("bp_release_valid", 64'(out_valid[0]), 64'd0);
      chk("bp_release_ready", 64'(in_ready[0]), 64'd1);
      wait_idle(0);

      // Busy refusal: second block waits for the first to drain.
      send(0, {$urandom, $urandom}, {8{$urandom}}, 1'b0);
      b2 = {$urandom, $urandom};
      in_valid[0] = 1'b1; blk[0] = b2; mode[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("busy_in_ready", 64'(in_ready[0]), 64'd0);
      end
      send(0, b2, key[0], 1'b0);
      chk("busy_accept_gap", 64'(last_acc[0]), 64'(last_hs[0] + 1));
      wait_idle(0);

      // Async reset mid-run.
      send(0, {$urandom, $urandom}, {8{$urandom}}, 1'b0);
      repeat (8) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
      chk("mid_rst_busy", 64'(busy[0]), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready[0]), 64'd0);
      chk("mid_rst_out", res[0], 64'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      seen_v = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid[0]) seen_v = 1;
      end
      chk("post_rst_no_valid", 64'(seen_v), 64'd0);
      send(0, {$urandom, $urandom}, {8{$urandom}}, 1'b1); wait_idle(0);

      // Eight-round build round trip.
      a = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send(1, a, k, 1'b0); wait_idle(1);
      send(1, model(a, k, 1'b0, 8), k, 1'b1); wait_idle(1);
      chk("r8_round_trip", last_out[1], a);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
